// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: post-reset startup sequencer in the core_clk domain.
// Optional SDRAM init retry on timeout: define RST_SEQ_RETRY_EN.
module rst_seq_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       core_clk,
  input  logic       clr_rst,
  input  logic       sample_rst_in,
  input  logic       sd_rst_in,
  input  logic       usb_rst_in,
  input  logic       sdram_rst_n_in,
  input  logic       sdram_init_done,
  input  logic       start,
  input  logic       stop,
  output logic       sdram_init_en,
  output logic       capture_en,
  output logic       seq_ready,
  output logic       seq_err,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_WAIT_RST   = 3'd0,
    S_SETTLE     = 3'd1,
    S_SDRAM_INIT = 3'd2,
    S_READY      = 3'd3,
    S_RUN        = 3'd4,
    S_ERROR      = 3'd5
  } state_t;

  // bit order: sample, sd, usb, sdram_rst_n, init_done
  localparam logic [4:0] SYNC_RST_VAL = 5'b00111;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [4:0]  w_async;
  logic [4:0]  r_sync [SYNC_STAGES];
  logic [4:0]  w_synced;
  logic        w_dom_rst;
  logic        w_done;
  logic        r_done_q;
  logic        w_done_fall;

  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

`ifdef RST_SEQ_RETRY_EN
  logic [1:0]  r_retry;
  logic [1:0]  w_retry_nxt;
`endif

  logic        r_init_en;
  logic        r_cap_en;
  logic        r_ready;
  logic        r_err;

  assign w_async = {sdram_init_done, sdram_rst_n_in,
                    usb_rst_in, sd_rst_in, sample_rst_in};

  // Multi-flop synchronizers; reset loads the "in reset / not done" value
  always_ff @(posedge core_clk or posedge clr_rst) begin
    if (clr_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= SYNC_RST_VAL;
      end
    end else begin
      r_sync[0] <= w_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_synced  = r_sync[SYNC_STAGES-1];
  assign w_dom_rst = |w_synced[2:0] | ~w_synced[3];
  assign w_done    = w_synced[4];

  // Delayed synced done for falling-edge detection while running
  always_ff @(posedge core_clk or posedge clr_rst) begin
    if (clr_rst) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= w_done;
    end
  end

  assign w_done_fall = r_done_q & ~w_done;

  // State, interval counter and retry count registers
  always_ff @(posedge core_clk or posedge clr_rst) begin
    if (clr_rst) begin
      r_state <= S_WAIT_RST;
      r_cnt   <= '0;
`ifdef RST_SEQ_RETRY_EN
      r_retry <= '0;
`endif
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef RST_SEQ_RETRY_EN
      r_retry <= w_retry_nxt;
`endif
    end
  end

  // Next-state, counter and retry logic; domain reset overrides all
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
`ifdef RST_SEQ_RETRY_EN
    w_retry_nxt = r_retry;
`endif
    unique case (r_state)
      S_WAIT_RST: begin
        w_cnt_nxt = '0;
        if (!w_dom_rst) begin
          w_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_nxt     = S_SDRAM_INIT;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_SDRAM_INIT: begin
        if (w_done) begin
          w_nxt     = S_READY;
          w_cnt_nxt = '0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_cnt_nxt = '0;
`ifdef RST_SEQ_RETRY_EN
          if (r_retry == 2'd3) begin
            w_nxt = S_ERROR;
          end else begin
            w_nxt       = S_SETTLE;
            w_retry_nxt = r_retry + 2'd1;
          end
`else
          w_nxt = S_ERROR;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_READY: begin
        w_cnt_nxt = '0;
        if (start && !stop) begin
          w_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cnt_nxt = '0;
        if (stop) begin
          w_nxt = S_READY;
        end else if (w_done_fall) begin
          w_nxt = S_WAIT_RST;
        end
      end
      S_ERROR: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_nxt     = S_WAIT_RST;
        w_cnt_nxt = '0;
      end
    endcase

    if (w_dom_rst && (r_state != S_WAIT_RST) && (r_state != S_ERROR)) begin
      w_nxt     = S_WAIT_RST;
      w_cnt_nxt = '0;
    end

`ifdef RST_SEQ_RETRY_EN
    if ((w_nxt == S_READY) || (w_nxt == S_WAIT_RST)) begin
      w_retry_nxt = '0;
    end
`endif
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge core_clk or posedge clr_rst) begin
    if (clr_rst) begin
      r_init_en <= 1'b0;
      r_cap_en  <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_init_en <= (w_nxt == S_SDRAM_INIT) || (w_nxt == S_READY) ||
                   (w_nxt == S_RUN);
      r_cap_en  <= (w_nxt == S_RUN);
      r_ready   <= (w_nxt == S_READY) || (w_nxt == S_RUN);
      r_err     <= (w_nxt == S_ERROR);
    end
  end

  assign sdram_init_en = r_init_en;
  assign capture_en    = r_cap_en;
  assign seq_ready     = r_ready;
  assign seq_err       = r_err;
  assign seq_state     = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: scoreboard bench for rst_seq_ctrl.
// Instance a uses defaults; instance b uses an 8-cycle timeout.
module tb_rst_seq_ctrl;

  localparam logic [6:0] E_WAIT = 7'b0000000;
  localparam logic [6:0] E_SET  = 7'b0000001;
  localparam logic [6:0] E_INIT = 7'b1000010;
  localparam logic [6:0] E_RDY  = 7'b1010011;
  localparam logic [6:0] E_RUN  = 7'b1110100;
  localparam logic [6:0] E_ERR  = 7'b0001101;

  typedef struct {
    int         cyc;
    bit         inst;
    logic [6:0] exp;
    string      nm;
  } exp_t;

  logic core_clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   fin_req = 1'b0;
  bit   fin_ack = 1'b0;
  exp_t q[$];

  logic a_clr, a_smp, a_sd, a_usb, a_srn, a_done, a_start, a_stop;
  logic a_ien, a_cap, a_rdy, a_err;
  logic [2:0] a_st;
  logic b_clr, b_smp, b_sd, b_usb, b_srn, b_done, b_start, b_stop;
  logic b_ien, b_cap, b_rdy, b_err;
  logic [2:0] b_st;

  logic [6:0] oa, ob;
  assign oa = {a_ien, a_cap, a_rdy, a_err, a_st};
  assign ob = {b_ien, b_cap, b_rdy, b_err, b_st};

  rst_seq_ctrl u_a (
    .core_clk(core_clk), .clr_rst(a_clr),
    .sample_rst_in(a_smp), .sd_rst_in(a_sd),
    .usb_rst_in(a_usb), .sdram_rst_n_in(a_srn),
    .sdram_init_done(a_done), .start(a_start), .stop(a_stop),
    .sdram_init_en(a_ien), .capture_en(a_cap),
    .seq_ready(a_rdy), .seq_err(a_err), .seq_state(a_st)
  );

  rst_seq_ctrl #(.TIMEOUT_CYCLES(8)) u_b (
    .core_clk(core_clk), .clr_rst(b_clr),
    .sample_rst_in(b_smp), .sd_rst_in(b_sd),
    .usb_rst_in(b_usb), .sdram_rst_n_in(b_srn),
    .sdram_init_done(b_done), .start(b_start), .stop(b_stop),
    .sdram_init_en(b_ien), .capture_en(b_cap),
    .seq_ready(b_rdy), .seq_err(b_err), .seq_state(b_st)
  );

  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due this cycle and compare
  always @(negedge core_clk) begin
    logic [6:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = q[i].inst ? ob : oa;
        checks++;
        if (q[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expired at cycle %0d (due %0d)",
                   q[i].nm, cyc, q[i].cyc);
        end else if (act !== q[i].exp) begin
          errors++;
          $display("FAIL %s: cycle %0d got %b expected %b",
                   q[i].nm, cyc, act, q[i].exp);
        end
        q.delete(i);
      end
    end
    if (fin_req && !fin_ack) begin
      if (q.size() != 0) begin
        errors += q.size();
        $display("FAIL leftover: %0d expectations never compared",
                 q.size());
      end
      fin_ack = 1'b1;
    end
  end

  task automatic exp_at(input int c, input bit inst,
                        input logic [6:0] e, input string nm);
    exp_t t;
    t.cyc  = c;
    t.inst = inst;
    t.exp  = e;
    t.nm   = nm;
    q.push_back(t);
  endtask

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  initial begin
    int c0, e, r, b0, f, z, g;
    a_clr = 1; a_smp = 1; a_sd = 1; a_usb = 1; a_srn = 0;
    a_done = 0; a_start = 0; a_stop = 0;
    b_clr = 1; b_smp = 0; b_sd = 0; b_usb = 0; b_srn = 1;
    b_done = 0; b_start = 0; b_stop = 0;

    at(2);
    exp_at(2, 0, E_WAIT, "a_reset");
    at(3);
    a_clr = 0;
    exp_at(5, 0, E_WAIT, "a_wait_held");

    c0 = 6;
    at(c0);
    a_smp = 0; a_sd = 0; a_usb = 0; a_srn = 1;
    exp_at(c0 + 2, 0, E_WAIT, "a_sync_delay");
    exp_at(c0 + 3, 0, E_SET, "a_settle_entry");
    exp_at(c0 + 18, 0, E_SET, "a_settle_last");
    e = c0 + 19;
    exp_at(e, 0, E_INIT, "a_init_entry");

    at(e + 10);
    a_done = 1;
    exp_at(e + 12, 0, E_INIT, "a_init_wait");
    exp_at(e + 13, 0, E_RDY, "a_ready");
    r = e + 13;

    at(r + 2);
    a_start = 1;
    exp_at(r + 2, 0, E_RDY, "a_pre_start");
    exp_at(r + 3, 0, E_RUN, "a_start");
    at(r + 3);
    a_start = 0;

    at(r + 6);
    a_stop = 1;
    exp_at(r + 6, 0, E_RUN, "a_pre_stop");
    exp_at(r + 7, 0, E_RDY, "a_stop");
    at(r + 7);
    a_stop = 0;

    at(r + 9);
    a_start = 1; a_stop = 1;
    exp_at(r + 10, 0, E_RDY, "a_start_stop");
    at(r + 10);
    a_start = 0; a_stop = 0;

    at(r + 12);
    a_start = 1;
    exp_at(r + 13, 0, E_RUN, "a_start2");
    at(r + 13);
    a_start = 0;

    at(r + 16);
    a_smp = 1;
    exp_at(r + 18, 0, E_RUN, "a_dom_pre");
    exp_at(r + 19, 0, E_WAIT, "a_dom_rst");

    at(r + 22);
    a_smp = 0;
    exp_at(r + 24, 0, E_WAIT, "a_dom_held");
    exp_at(r + 25, 0, E_SET, "a_restart");
    exp_at(r + 41, 0, E_INIT, "a_init2");
    exp_at(r + 42, 0, E_RDY, "a_ready2");

    at(r + 44);
    a_start = 1;
    exp_at(r + 45, 0, E_RUN, "a_start3");
    at(r + 45);
    a_start = 0;

    at(r + 48);
    a_done = 0;
    exp_at(r + 50, 0, E_RUN, "a_fall_pre");
    exp_at(r + 51, 0, E_WAIT, "a_done_fall");
    exp_at(r + 52, 0, E_SET, "a_resettle");

    at(r + 54);
    exp_at(r + 55, 0, E_SET, "a_settle_mid");
    at(r + 56);
    a_clr = 1;
    exp_at(r + 56, 0, E_WAIT, "a_clr_async");
    exp_at(r + 58, 0, E_WAIT, "a_clr_hold");

    b0 = r + 60;
    at(b0 - 1);
    exp_at(b0 - 1, 1, E_WAIT, "b_reset");
    at(b0);
    b_clr = 0;
    f = b0 + 19;
    exp_at(f - 1, 1, E_SET, "b_settle");
    exp_at(f, 1, E_INIT, "b_init");
    exp_at(f + 7, 1, E_INIT, "b_init_last");
`ifdef RST_SEQ_RETRY_EN
    for (int i = 1; i <= 3; i++) begin
      exp_at(f + 24 * i - 16, 1, E_SET, "b_retry_settle");
      exp_at(f + 24 * i, 1, E_INIT, "b_retry_init");
    end
    exp_at(f + 79, 1, E_INIT, "b_retry_last");
    exp_at(f + 80, 1, E_ERR, "b_retry_error");
    z = f + 80;
`else
    exp_at(f + 8, 1, E_ERR, "b_timeout");
    z = f + 8;
`endif

    at(z + 2);
    b_done = 1;
    at(z + 4);
    b_smp = 1;
    exp_at(z + 12, 1, E_ERR, "b_err_sticky");
    at(z + 13);
    b_done = 0; b_smp = 0;
    at(z + 14);
    b_clr = 1;
    exp_at(z + 14, 1, E_WAIT, "b_err_clear");

    at(z + 16);
    b_clr = 0;
    g = z + 35;
    exp_at(g, 1, E_INIT, "b_init3");
    at(g + 5);
    b_done = 1;
    exp_at(g + 7, 1, E_INIT, "b_edge_pre");
    exp_at(g + 8, 1, E_RDY, "b_done_on_timeout");
    exp_at(g + 10, 1, E_RDY, "b_no_err");

    at(g + 12);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) begin
      @(posedge core_clk);
    end
    if (!fin_ack) begin
      $display("FAIL monitor_stall: fin_ack=%0d required 1", fin_ack);
      $fatal(1, "monitor stalled");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
